lfsr_decrypt_engine: RTL and testbench
======================================

LFSR_DECRYPT_ENGINE -- requirements
Module: lfsr_decrypt_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- LFSR_W, 7: LFSR state width.
- DATA_W, 8: memory byte width; MSB is parity, and LFSR_W must equal DATA_W-1.
- ADDR_W, 8: memory address width.
- MSG_LEN, 64: bytes to decrypt.
- SRC_BASE, 64: first encrypted byte address.
- DST_BASE, 0: first plaintext byte address.
- CHECK_LEN, 8: preamble bytes used for pattern search; range 2..10.
- NUM_PTRN, 9: candidate tap patterns.
- PTRN_TBL, {60,48,78,72,6A,69,5C,7E,7B}h: packed NUM_PTRN*LFSR_W table; entry 0 is 0x60.
REQ-002 Ports, one per line: name, direction, width, meaning.
- Clk, in, 1: single clock; all state updates on the rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Start, in, 1: high holds the engine idle; the falling edge launches a run.
- Ack, out, 1: run complete.
- mem_addr, out, ADDR_W: shared read/write address.
- mem_rd_data, in, DATA_W: data for the address issued in the previous cycle.
- mem_wr_en, out, 1: write strobe.
- mem_wr_data, out, DATA_W: write data.
- ptrn_idx, out, 4: index of the matched pattern.
- no_match, out, 1: no pattern fit the preamble.
- par_err_cnt, out, 7: count of parity failures.

Function
REQ-003 LFSR step: next = {s[LFSR_W-2:0], ^(s & taps)}.
REQ-004 State machine: IDLE, FETCH, SEARCH, DECRYPT, DONE.
REQ-005 IDLE: registered Start high on one cycle and low on the next (falling edge) moves the engine to FETCH.
- Counters and status outputs clear on entry to FETCH.
REQ-006 FETCH: for k=0..CHECK_LEN-1, the engine issues read SRC_BASE+k and captures the data on the following cycle into buf[k][LFSR_W-1:0].
- Duration: 2*CHECK_LEN cycles.
REQ-007 Seed: s0 = buf[0].
- If s0==0, the engine sets no_match=1 and goes directly to DONE.
REQ-008 SEARCH: for pattern p=0..NUM_PTRN-1, the engine steps s from s0, one step per cycle.
- At step k, the predicted state must equal buf[k]; the preamble plaintext is 0x00 after the 0x20 bias.
- First mismatch: abandon p next cycle and restart from s0 with p+1.
- All CHECK_LEN-1 steps match: latch ptrn_idx=p and go to DECRYPT.
- All patterns fail: no_match=1, then DONE; no memory writes occur.
REQ-009 The lowest matching pattern index wins.
REQ-010 DECRYPT, per byte i=0..MSG_LEN-1, two cycles, state restarting at s0:
- Cycle A: mem_addr=SRC_BASE+i, mem_wr_en=0.
- Cycle B: mem_addr=DST_BASE+i, mem_wr_en=1, mem_wr_data = ({1'b0, rd[LFSR_W-1:0]^s} + 0x20) mod 2^DATA_W; then advance s one step.
REQ-011 Parity: in cycle B, if rd[DATA_W-1] != ^rd[LFSR_W-1:0], par_err_cnt increments.
- par_err_cnt saturates at 127.
- The written data is unaffected by the parity result.
REQ-012 Address arithmetic is mod 2^ADDR_W; wrap-around is permitted and is not flagged.
REQ-013 DECRYPT duration: exactly 2*MSG_LEN cycles; exactly MSG_LEN writes, in ascending address order.
REQ-014 DONE: Ack=1 and ptrn_idx, no_match, par_err_cnt are held stable.
- Start high returns the engine to IDLE, with Ack=0 on the next cycle.
REQ-015 Start activity outside IDLE and DONE is ignored.
REQ-016 mem_wr_en=0 in every state except DECRYPT cycle B.
- mem_addr=0 in IDLE and DONE.

Reset
REQ-017 Reset forces, asynchronously and from any state including mid-write:
- state=IDLE
- Ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0
- ptrn_idx=0, no_match=0, par_err_cnt=0
- the LFSR state register, all counters, and buf cleared to 0
REQ-018 After Reset deasserts, a Start falling edge is required before any memory access.
REQ-019 No partial-run state survives Reset; the memory contents already written are not restored.

Verification
REQ-020 Pattern 0x6A (idx 4), init 0x01, 19-space preamble, message " Knowledge comes, but wisdom lingers." -> ptrn_idx=4, no_match=0, par_err_cnt=0, DST[0..63] equal the padded plaintext, Ack high after 2*CHECK_LEN + search + 128 cycles.
REQ-021 Pattern 0x60 (idx 0), init 0x7F -> search completes in CHECK_LEN-1 cycles; ptrn_idx=0.
REQ-022 SRC[64]=0x80 (seed 0) -> no_match=1, Ack high after 2*CHECK_LEN+1 cycles, mem_wr_en never asserted.
REQ-023 Valid run with the parity bit flipped in SRC[70] and SRC[100] -> par_err_cnt=2, and DST[6] and DST[36] still decrypt correctly.
REQ-024 Reset pulsed during DECRYPT after the 10th write -> mem_wr_en=0 immediately and Ack=0; a new Start run then rewrites DST[0..63] correctly.
REQ-025 Start held high throughout -> no memory access and Ack=0; after DONE, Start high -> Ack=0 next cycle, and a second falling edge reruns with identical results.

Source files
------------

// File: rtl/lfsr_decrypt_engine.sv
// LFSR stream decryptor.
// The engine reads an encrypted preamble and searches a table of tap patterns
// for one that reproduces it. It then decrypts MSG_LEN bytes from SRC_BASE to
// DST_BASE and counts parity failures along the way.
//
// Memory handshake: the memory has no valid/ready pair. An address driven in
// cycle t returns its data on mem_rd_data in cycle t+1. A write happens at the
// rising edge that ends any cycle in which mem_wr_en=1. Both the read address
// and the write address use the single mem_addr bus.
module lfsr_decrypt_engine #(
  parameter int LFSR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MSG_LEN   = 64,
  parameter int SRC_BASE  = 64,
  parameter int DST_BASE  = 0,
  parameter int CHECK_LEN = 8,
  parameter int NUM_PTRN  = 9,
  parameter logic [NUM_PTRN*LFSR_W-1:0] PTRN_TBL =
    {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B}
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [3:0]        ptrn_idx,
  output logic              no_match,
  output logic [6:0]        par_err_cnt,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2((MSG_LEN > CHECK_LEN) ? 2*MSG_LEN : 2*CHECK_LEN) + 1;
  localparam int IDX_W = (CHECK_LEN > 1) ? $clog2(CHECK_LEN) : 1;
  localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
  localparam logic [DATA_W-1:0] BIAS  = DATA_W'(32);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SEARCH  = 3'd2,
    S_DECRYPT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                start_q, start_qq;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LFSR_W-1:0]   s_q, s_d;
  logic [3:0]          p_q, p_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [3:0]          ptrn_d;
  logic                nm_d;
  logic [6:0]          par_d;
  logic                buf_we;
  logic [IDX_W-1:0]    buf_idx;
  logic [ADDR_W-1:0]   byte_off;
  logic [LFSR_W-1:0]   taps_cur;
  logic [LFSR_W-1:0]   step_nxt;
  logic [LFSR_W-1:0]   pre_buf [CHECK_LEN];

  assign Ack       = (state_q == S_DONE);
  assign dbg_state = state_q;
  assign buf_idx   = IDX_W'(cnt_q >> 1);
  assign byte_off  = ADDR_W'(cnt_q >> 1);

  // Select the tap pattern currently under test (entry 0 sits in the MSBs).
  always_comb begin
    taps_cur = '0;
    for (int i = 0; i < NUM_PTRN; i++) begin
      if (p_q == 4'(i)) taps_cur = PTRN_TBL[(NUM_PTRN-1-i)*LFSR_W +: LFSR_W];
    end
  end

  assign step_nxt = {s_q[LFSR_W-2:0], ^(s_q & taps_cur)};

  // Next-state, datapath next values and memory-bus outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    p_d         = p_q;
    k_d         = k_q;
    ptrn_d      = ptrn_idx;
    nm_d        = no_match;
    par_d       = par_err_cnt;
    buf_we      = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (start_qq && !start_q) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          ptrn_d  = '0;
          nm_d    = 1'b0;
          par_d   = '0;
        end
      end
      S_FETCH: begin
        // Even cycles issue the read; odd cycles capture the returned byte.
        mem_addr = SRC_A + byte_off;
        cnt_d    = cnt_q + CNT_W'(1);
        buf_we   = cnt_q[0];
        if (cnt_q == CNT_W'(2*CHECK_LEN-1)) begin
          state_d = S_SEARCH;
          cnt_d   = '0;
          s_d     = pre_buf[0];
          p_d     = '0;
          k_d     = IDX_W'(1);
        end
      end
      S_SEARCH: begin
        if (pre_buf[0] == '0) begin
          // A zero seed locks the LFSR at zero, so nothing can be decrypted.
          nm_d    = 1'b1;
          state_d = S_DONE;
        end else if (step_nxt != pre_buf[k_q]) begin
          if (p_q == 4'(NUM_PTRN-1)) begin
            nm_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            p_d = p_q + 4'd1;
            s_d = pre_buf[0];
            k_d = IDX_W'(1);
          end
        end else if (k_q == IDX_W'(CHECK_LEN-1)) begin
          ptrn_d  = p_q;
          s_d     = pre_buf[0];
          cnt_d   = '0;
          state_d = S_DECRYPT;
        end else begin
          s_d = step_nxt;
          k_d = k_q + IDX_W'(1);
        end
      end
      S_DECRYPT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!cnt_q[0]) begin
          mem_addr = SRC_A + byte_off;
        end else begin
          mem_addr    = DST_A + byte_off;
          mem_wr_en   = 1'b1;
          mem_wr_data = {1'b0, mem_rd_data[LFSR_W-1:0] ^ s_q} + BIAS;
          s_d         = step_nxt;
          if ((mem_rd_data[DATA_W-1] != ^mem_rd_data[LFSR_W-1:0]) && (par_err_cnt != 7'h7F))
            par_d = par_err_cnt + 7'd1;
          if (cnt_q == CNT_W'(2*MSG_LEN-1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (Start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and status registers, all cleared by the asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      start_qq    <= 1'b0;
      cnt_q       <= '0;
      s_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      ptrn_idx    <= '0;
      no_match    <= 1'b0;
      par_err_cnt <= '0;
      for (int i = 0; i < CHECK_LEN; i++) pre_buf[i] <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= Start;
      start_qq    <= start_q;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      p_q         <= p_d;
      k_q         <= k_d;
      ptrn_idx    <= ptrn_d;
      no_match    <= nm_d;
      par_err_cnt <= par_d;
      if (buf_we) pre_buf[buf_idx] <= mem_rd_data[LFSR_W-1:0];
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Bench for lfsr_decrypt_engine: encrypts known and random plaintexts,
// predicts the search result, timing and every write, and checks the DUT.
module tb_lfsr_decrypt_engine;

  localparam int MSG_LEN   = 64;
  localparam int SRC_BASE  = 64;
  localparam int DST_BASE  = 0;
  localparam int CHECK_LEN = 8;
  localparam int NUM_PTRN  = 9;

  // ---------------- clock / reset ----------------
  logic       Clk, Reset, Start;
  logic       Ack, mem_wr_en, no_match;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
  logic [3:0] ptrn_idx;
  logic [6:0] par_err_cnt;
  logic [2:0] dbg_state;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  lfsr_decrypt_engine dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .ptrn_idx(ptrn_idx), .no_match(no_match), .par_err_cnt(par_err_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  logic [7:0] src_img [MSG_LEN];
  logic [7:0] mem [256];
  logic       clr_req;

  always @(posedge Clk) begin
    if (clr_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
    end
    if (mem_addr >= 8'(SRC_BASE) && mem_addr < 8'(SRC_BASE + MSG_LEN))
      mem_rd_data <= src_img[mem_addr - 8'(SRC_BASE)];
    else
      mem_rd_data <= mem[mem_addr];
  end

  // ---------------- reference model ----------------
  logic [6:0]  taps_tbl [NUM_PTRN] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  logic [7:0]  pt [MSG_LEN];
  logic [7:0]  m_dst [MSG_LEN];
  int          m_ptrn, m_nm, m_par, m_search, m_lat;
  logic [15:0] exp_q [$];
  int          total, bad;
  logic        mon_on;

  function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] t);
    int ones;
    ones = $countones(s & t);
    return {s[5:0], 1'(ones % 2)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Encrypt pt[] with the given taps and initial state into src_img[].
  task automatic encrypt(input logic [6:0] taps, input logic [6:0] init);
    logic [6:0] s, c;
    s = init;
    for (int i = 0; i < MSG_LEN; i++) begin
      c = 7'(pt[i] - 8'h20) ^ s;
      src_img[i] = {^c, c};
      s = lfsr_next(s, taps);
    end
  endtask

  // Predict search outcome, latency, parity count, written bytes from src_img.
  task automatic model_run();
    logic [6:0] pre [CHECK_LEN];
    logic [6:0] s;
    logic [7:0] b;
    int found;
    bit ok;
    for (int k = 0; k < CHECK_LEN; k++) pre[k] = src_img[k][6:0];
    m_ptrn = 0; m_nm = 0; m_par = 0; m_search = 0;
    exp_q.delete();
    for (int i = 0; i < MSG_LEN; i++) m_dst[i] = 8'hEE;
    if (pre[0] == 7'd0) begin
      m_nm = 1;
      m_search = 1;
    end else begin
      found = -1;
      for (int p = 0; p < NUM_PTRN && found < 0; p++) begin
        s = pre[0];
        ok = 1'b1;
        for (int k = 1; k < CHECK_LEN && ok; k++) begin
          s = lfsr_next(s, taps_tbl[p]);
          m_search++;
          if (s != pre[k]) ok = 1'b0;
        end
        if (ok) found = p;
      end
      if (found < 0) m_nm = 1; else m_ptrn = found;
    end
    if (m_nm == 0) begin
      s = pre[0];
      for (int i = 0; i < MSG_LEN; i++) begin
        b = src_img[i];
        m_dst[i] = {1'b0, b[6:0] ^ s} + 8'h20;
        exp_q.push_back({8'(DST_BASE + i), m_dst[i]});
        if ((b[7] != ^b[6:0]) && m_par < 127) m_par++;
        s = lfsr_next(s, taps_tbl[m_ptrn]);
      end
    end
    // Two cycles of Start synchronisation, then fetch, search and decrypt.
    m_lat = 2 + 2*CHECK_LEN + m_search + ((m_nm != 0) ? 0 : 2*MSG_LEN);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge Clk) begin
    if (mon_on && !Reset && mem_wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", {mem_addr, mem_wr_data}, 32'hFFFF_FFFF);
      else check("wr_addr_data", {mem_addr, mem_wr_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_dst();
    clr_req = 1'b1;
    @(posedge Clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic idle_hold(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check(name, {Ack, mem_wr_en, mem_addr}, 32'd0);
    end
  endtask

  task automatic launch();
    clear_dst();
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    check("pre_launch_idle", {Ack, mem_wr_en, mem_addr}, 32'd0);
    mon_on = 1'b1;
    Start = 1'b0;
  endtask

  task automatic run_case(input string tag);
    int cyc;
    model_run();
    launch();
    cyc = 0;
    while (!Ack && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, m_lat);
    check({tag, "_ptrn_idx"}, ptrn_idx, m_ptrn);
    check({tag, "_no_match"}, no_match, m_nm);
    check({tag, "_par_err"}, par_err_cnt, m_par);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    for (int i = 0; i < MSG_LEN; i++) check({tag, "_dst"}, mem[DST_BASE + i], m_dst[i]);
    repeat (2) begin
      @(negedge Clk);
      check({tag, "_done_hold"}, {Ack, mem_wr_en, mem_addr, ptrn_idx, no_match, par_err_cnt},
            {1'b1, 1'b0, 8'd0, 4'(m_ptrn), 1'(m_nm), 7'(m_par)});
    end
    Start = 1'b1;
    @(negedge Clk);
    check({tag, "_ack_drop"}, Ack, 1'b0);
    mon_on = 1'b0;
  endtask

  task automatic build_knowledge();
    string msg;
    msg = " Knowledge comes, but wisdom lingers.";
    for (int i = 0; i < MSG_LEN; i++)
      pt[i] = (i >= 19 && (i - 19) < msg.len()) ? msg[i - 19] : 8'h20;
  endtask

  task automatic reset_mid_run();
    int n, guard;
    build_knowledge();
    encrypt(7'h6A, 7'h01);
    model_run();
    launch();
    n = 0; guard = 0;
    while (n < 10 && guard < 1000) begin
      @(negedge Clk);
      guard++;
      if (mem_wr_en) n++;
    end
    check("rst_write_count", n, 10);
    #1 Reset = 1'b1;
    #1;
    check("rst_outputs", {Ack, mem_wr_en, mem_addr, mem_wr_data}, 32'd0);
    check("rst_status", {ptrn_idx, no_match, par_err_cnt}, 32'd0);
    mon_on = 1'b0;
    exp_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    idle_hold("rst_no_access", 10);
    run_case("after_reset");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total = 0; bad = 0; mon_on = 1'b0; clr_req = 1'b0;
    Reset = 1'b1; Start = 1'b1;
    for (int i = 0; i < MSG_LEN; i++) src_img[i] = 8'h00;
    repeat (3) @(negedge Clk);
    check("reset_state", {Ack, mem_wr_en, mem_addr, mem_wr_data, ptrn_idx, no_match, par_err_cnt}, 32'd0);
    Reset = 1'b0;
    idle_hold("start_held_high", 20);

    // Known message, pattern 0x6A (index 4), initial state 0x01.
    build_knowledge();
    encrypt(7'h6A, 7'h01);
    model_run();
    check("model_ptrn_k", m_ptrn, 4);
    check("model_search_k", m_search, 17);
    check("model_lat_k", m_lat, 163);
    check("model_plain_k", m_dst[20], 8'h4B);
    run_case("knowledge");
    run_case("knowledge_rerun");

    // Pattern 0 matches on the first try.
    encrypt(7'h60, 7'h7F);
    model_run();
    check("model_search_p0", m_search, CHECK_LEN - 1);
    check("model_lat_p0", m_lat, 153);
    run_case("pattern0");

    // Zero seed.
    encrypt(7'h6A, 7'h01);
    src_img[0] = 8'h80;
    model_run();
    check("model_lat_seed0", m_lat, 19);
    run_case("seed_zero");

    // Preamble that no table entry can produce.
    encrypt(7'h6A, 7'h01);
    src_img[1] = 8'hFF;
    model_run();
    check("model_lat_nomatch", m_lat, 27);
    run_case("all_fail");

    // Parity bits flipped in two bytes.
    encrypt(7'h6A, 7'h01);
    src_img[6]  = src_img[6]  ^ 8'h80;
    src_img[36] = src_img[36] ^ 8'h80;
    model_run();
    check("model_par", m_par, 2);
    check("model_plain_6", m_dst[6], pt[6]);
    check("model_plain_36", m_dst[36], pt[36]);
    run_case("parity");

    // Randomised runs: random taps/seed/plaintext, parity flips, or raw noise.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < MSG_LEN; i++)
        pt[i] = (i < CHECK_LEN) ? 8'h20 : 8'($urandom_range(32, 126));
      encrypt(taps_tbl[$urandom_range(0, NUM_PTRN - 1)], 7'($urandom_range(1, 127)));
      repeat ($urandom_range(0, 4)) begin
        int j;
        j = $urandom_range(0, MSG_LEN - 1);
        src_img[j] = src_img[j] ^ 8'h80;
      end
      if (r % 4 == 3)
        for (int i = 0; i < MSG_LEN; i++) src_img[i] = 8'($urandom_range(0, 255));
      run_case("random");
    end

    reset_mid_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
